// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file's single write port,
// with two combinational youngest-first bypass lookups over queued entries.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     rf_hold,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_addr,
    output logic [DW-1:0]            rf_data,
    input  logic [AW-1:0]            lk_addr1,
    input  logic [AW-1:0]            lk_addr2,
    output logic                     lk_hit1,
    output logic                     lk_hit2,
    output logic [DW-1:0]            lk_data1,
    output logic [DW-1:0]            lk_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [PW-1:0] w_idx;
    logic          w_hit1;
    logic          w_hit2;
    logic [DW-1:0] w_dat1;
    logic [DW-1:0] w_dat2;

    // A full queue refuses input even when it drains on the same edge.
    assign in_ready   = reset && (r_count < CW'(DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_push     = in_valid && in_ready && (in_addr != '0);
    assign w_pop      = w_nonempty && !rf_hold;

    assign rf_we   = w_pop;
    assign rf_addr = w_nonempty ? r_addr[r_rptr] : '0;
    assign rf_data = w_nonempty ? r_data[r_rptr] : '0;
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= in_addr;
            r_data[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_dat1 = '0;
        w_dat2 = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PW'(i);
            if (CW'(i) < r_count) begin
                if ((lk_addr1 != '0) && (r_addr[w_idx] == lk_addr1)) begin
                    w_hit1 = 1'b1;
                    w_dat1 = r_data[w_idx];
                end
                if ((lk_addr2 != '0) && (r_addr[w_idx] == lk_addr2)) begin
                    w_hit2 = 1'b1;
                    w_dat2 = r_data[w_idx];
                end
            end
        end
    end

    assign lk_hit1  = w_hit1;
    assign lk_hit2  = w_hit2;
    assign lk_data1 = w_dat1;
    assign lk_data2 = w_dat2;

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized and directed bench for wb_write_queue against a queue-based model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          rf_hold;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] lk_addr1;
    logic [AW-1:0] lk_addr2;
    logic          lk_hit1;
    logic          lk_hit2;
    logic [DW-1:0] lk_data1;
    logic [DW-1:0] lk_data2;
    logic [2:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_hold  (rf_hold),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .lk_addr1 (lk_addr1),
        .lk_addr2 (lk_addr2),
        .lk_hit1  (lk_hit1),
        .lk_hit2  (lk_hit2),
        .lk_data1 (lk_data1),
        .lk_data2 (lk_data2),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] model_lookup(input logic [AW-1:0] a);
        if (a == '0) return '0;
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].a == a) return {1'b1, mq[k].d};
        end
        return '0;
    endfunction

    // Model: a plain in-order list; drain the head, then append accepted non-x0 results.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            int  sz;
            bit  rdy;
            sz  = mq.size();
            rdy = (sz < DEPTH);
            if (sz != 0 && !rf_hold) void'(mq.pop_front());
            if (in_valid && rdy && in_addr != '0) mq.push_back({in_addr, in_data});
        end
    end

    // Compare every cycle, well after inputs change and before the next rising edge.
    always @(negedge clk) begin
        logic [DW:0] l1;
        logic [DW:0] l2;
        int          sz;
        #3;
        sz = mq.size();
        l1 = model_lookup(lk_addr1);
        l2 = model_lookup(lk_addr2);
        chk("in_ready", 64'(in_ready), 64'(reset && sz < DEPTH));
        chk("count",    64'(count),    64'(sz));
        chk("rf_we",    64'(rf_we),    64'(sz != 0 && !rf_hold));
        chk("rf_addr",  64'(rf_addr),  (sz != 0) ? 64'(mq[0].a) : 64'(0));
        chk("rf_data",  64'(rf_data),  (sz != 0) ? 64'(mq[0].d) : 64'(0));
        chk("lk_hit1",  64'(lk_hit1),  64'(l1[DW]));
        chk("lk_data1", 64'(lk_data1), 64'(l1[DW-1:0]));
        chk("lk_hit2",  64'(lk_hit2),  64'(l2[DW]));
        chk("lk_data2", 64'(lk_data2), 64'(l2[DW-1:0]));
    end

    task automatic drive(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit h, input logic [AW-1:0] l1, input logic [AW-1:0] l2);
        @(negedge clk);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        rf_hold  = h;
        lk_addr1 = l1;
        lk_addr2 = l2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_len;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        rf_hold  = 1'b0;
        lk_addr1 = '0;
        lk_addr2 = '0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_count",    64'(count),    64'(0));
        chk("rst_rf_we",    64'(rf_we),    64'(0));
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("rel_in_ready", 64'(in_ready), 64'(1));

        // Single write x5
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t1_we",    64'(rf_we),   64'(1));
        chk("t1_addr",  64'(rf_addr), 64'(5));
        chk("t1_data",  64'(rf_data), 64'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t1_count", 64'(count), 64'(0));

        // Fill under hold, refuse fifth, drain in order
        for (int i = 1; i <= 4; i++) drive(1, AW'(i), DW'(i), 1, 0, 0);
        drive(1, 9, 32'h99, 1, 0, 0);
        #2;
        chk("t2_full_count", 64'(count),    64'(4));
        chk("t2_full_ready", 64'(in_ready), 64'(0));
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            #2;
            chk("t2_drain_data",  64'(rf_data), 64'(i));
            chk("t2_drain_count", 64'(count),   64'(5 - i));
        end
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t2_empty", 64'(count), 64'(0));

        // Youngest-first bypass
        drive(1, 7, 32'h10, 1, 0, 0);
        drive(1, 7, 32'h20, 1, 0, 0);
        drive(0, 0, 0, 1, 7, 8);
        #2;
        chk("t3_hit1",  64'(lk_hit1),  64'(1));
        chk("t3_data1", 64'(lk_data1), 64'h20);
        chk("t3_hit2",  64'(lk_hit2),  64'(0));
        chk("t3_data2", 64'(lk_data2), 64'(0));
        drive(0, 0, 0, 0, 7, 8);
        #2;
        chk("t3_drain_hit", 64'(lk_hit1), 64'(1));
        chk("t3_drain0",    64'(rf_data), 64'h10);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t3_drain1",    64'(rf_data), 64'h20);
        drive(0, 0, 0, 0, 0, 0);

        // x0 write is accepted but discarded
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        #2;
        chk("t4_ready", 64'(in_ready), 64'(1));
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t4_count", 64'(count),   64'(0));
        chk("t4_we",    64'(rf_we),   64'(0));
        chk("t4_hit",   64'(lk_hit1), 64'(0));

        // Sustained enqueue plus drain across pointer wrap
        drive(1, 1, 32'h100, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, AW'((i % 31) + 1), DW'(32'h100 + i), 0, 0, 0);
            #2;
            chk("t5_count", 64'(count),   64'(1));
            chk("t5_data",  64'(rf_data), 64'(32'h100 + i - 1));
            chk("t5_addr",  64'(rf_addr), 64'(((i - 1) % 31) + 1));
        end
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t5_last", 64'(rf_data), 64'h10A);
        drive(0, 0, 0, 0, 0, 0);

        // Asynchronous reset with entries in flight
        drive(1, 3, 32'h33, 1, 0, 0);
        drive(1, 4, 32'h44, 1, 0, 0);
        drive(1, 5, 32'h55, 1, 0, 0);
        drive(0, 0, 0, 0, 4, 5);
        #2;
        chk("t6_pre_count", 64'(count),   64'(3));
        chk("t6_pre_we",    64'(rf_we),   64'(1));
        chk("t6_pre_hit",   64'(lk_hit1), 64'(1));
        reset = 1'b0;
        #1;
        chk("t6_rst_we",    64'(rf_we),    64'(0));
        chk("t6_rst_count", 64'(count),    64'(0));
        chk("t6_rst_hit1",  64'(lk_hit1),  64'(0));
        chk("t6_rst_hit2",  64'(lk_hit2),  64'(0));
        chk("t6_rst_addr",  64'(rf_addr),  64'(0));
        chk("t6_rst_ready", 64'(in_ready), 64'(0));
        drive(0, 0, 0, 0, 4, 5);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t6_post_we",    64'(rf_we), 64'(0));
            chk("t6_post_count", 64'(count), 64'(0));
            drive(0, 0, 0, 0, 4, 5);
        end

        // Random traffic with hold bursts and frequent address collisions
        hold_len = 0;
        for (int i = 0; i < 600; i++) begin
            bit h;
            if (hold_len == 0 && $urandom_range(0, 19) == 0) hold_len = $urandom_range(1, 8);
            h = (hold_len > 0) || ($urandom_range(0, 3) == 0);
            if (hold_len > 0) hold_len--;
            drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), $urandom, h,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
